// File: rtl/uart_switch_pkg.sv
// uart_switch_pkg: command/reply byte codes, FSM state encoding and a saturating increment
package uart_switch_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_ARG, BBM, TX_SEND, TX_ACK, TX_DONE} state_t;
  localparam logic [7:0] CMD_U = 8'h55, CMD_S = 8'h53, CMD_Q = 8'h51, CMD_O = 8'h4F;
  localparam logic [7:0] RSP_P = 8'h50, RSP_K = 8'h4B, RSP_E = 8'h45, RSP_X = 8'h58, ASCII_0 = 8'h30;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/uart_switch_ctrl_if.sv
// uart_switch_ctrl_if: UART-side bus (rx_data/rx_new/tx_busy in, tx_send/tx_data out of the controller)
interface uart_switch_ctrl_if;
  logic [7:0] rx_data;
  logic rx_new;
  logic tx_busy;
  logic tx_send;
  logic [7:0] tx_data;
  modport master (output rx_data, rx_new, tx_busy, input tx_send, tx_data);
  modport slave (input rx_data, rx_new, tx_busy, output tx_send, tx_data);
endinterface

// File: rtl/uart_switch_ctrl_rx_edge_detect.sv
// rx_edge_detect: one-cycle rx_byte on each 0->1 of rx_new (clk_50, rst, rx_new in; rx_byte out)
module rx_edge_detect (
  input  logic clk_50,
  input  logic rst,
  input  logic rx_new,
  output logic rx_byte
);
  logic rx_q;
  // resets high so a flag held through reset is never taken as a byte
  always_ff @(posedge clk_50) rx_q <= rst ? 1'b1 : rx_new;
  assign rx_byte = rx_new & ~rx_q;
endmodule

// File: rtl/uart_switch_ctrl.sv
// uart_switch_ctrl: UART command-driven break-before-make switch (clk_50, rst, bus.slave; sw_sel, sw_busy, err_cnt out)
module uart_switch_ctrl
  import uart_switch_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int BBM_CYC     = 50,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                 clk_50,
  input  logic                 rst,
  uart_switch_ctrl_if.slave    bus,
  output logic [NUM_CH-1:0]    sw_sel,
  output logic                 sw_busy,
  output logic [7:0]           err_cnt
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int BB_W = $clog2(BBM_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_n;
  logic off, off_n, tx_send_n, rx_byte, arg_ok;
  logic [CH_W-1:0] cur_ch, cur_ch_n, tgt, tgt_n, arg_ch;
  logic [BB_W-1:0] bbm, bbm_n;
  logic [TO_W-1:0] tmo, tmo_n;
  logic [NUM_CH-1:0] sw_sel_n;
  logic [7:0] tx_data_n, err_n;
  rx_edge_detect u_rx (.clk_50(clk_50), .rst(rst), .rx_new(bus.rx_new), .rx_byte(rx_byte));
  assign arg_ch = CH_W'(bus.rx_data - ASCII_0);
  assign arg_ok = bus.rx_data >= ASCII_0 && bus.rx_data < ASCII_0 + 8'(NUM_CH);
  assign sw_busy = state != IDLE && state != WAIT_ARG;
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state       <= IDLE;
      sw_sel      <= '0;
      off         <= 1'b1;
      cur_ch      <= '0;
      tgt         <= '0;
      bbm         <= '0;
      tmo         <= '0;
      bus.tx_send <= 1'b0;
      bus.tx_data <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      sw_sel      <= sw_sel_n;
      off         <= off_n;
      cur_ch      <= cur_ch_n;
      tgt         <= tgt_n;
      bbm         <= bbm_n;
      tmo         <= tmo_n;
      bus.tx_send <= tx_send_n;
      bus.tx_data <= tx_data_n;
      err_cnt     <= err_n;
    end
  end
  always_comb begin
    state_n   = state;
    sw_sel_n  = sw_sel;
    off_n     = off;
    cur_ch_n  = cur_ch;
    tgt_n     = tgt;
    bbm_n     = bbm;
    tmo_n     = tmo;
    tx_send_n = 1'b0;
    tx_data_n = bus.tx_data;
    err_n     = err_cnt;
    // bytes landing while the block is busy are discarded and counted
    if (rx_byte && sw_busy) err_n = sat_inc(err_n);
    case (state)
      IDLE: if (rx_byte) begin
        state_n = TX_SEND;
        case (bus.rx_data)
          CMD_U: tx_data_n = RSP_P;
          CMD_S: begin
            state_n = WAIT_ARG;
            tmo_n   = '0;
          end
          CMD_Q: tx_data_n = off ? RSP_X : ASCII_0 + 8'(cur_ch);
          CMD_O: begin
            sw_sel_n  = '0;
            off_n     = 1'b1;
            tx_data_n = RSP_K;
          end
          default: begin
            tx_data_n = RSP_E;
            err_n     = sat_inc(err_n);
          end
        endcase
      end
      // a byte in the expiry cycle wins over the timeout
      WAIT_ARG: if (rx_byte) begin
        state_n = TX_SEND;
        if (!arg_ok) begin
          tx_data_n = RSP_E;
          err_n     = sat_inc(err_n);
        end else if (!off && arg_ch == cur_ch) tx_data_n = RSP_K;
        else begin
          state_n  = BBM;
          sw_sel_n = '0;
          tgt_n    = arg_ch;
          bbm_n    = '0;
        end
      end else if (tmo == TO_W'(TIMEOUT_CYC - 1)) begin
        state_n = IDLE;
        err_n   = sat_inc(err_n);
      end else tmo_n = tmo + 1'b1;
      BBM: if (bbm == BB_W'(BBM_CYC - 1)) begin
        state_n   = TX_SEND;
        sw_sel_n  = NUM_CH'(1) << tgt;
        cur_ch_n  = tgt;
        off_n     = 1'b0;
        tx_data_n = RSP_K;
      end else bbm_n = bbm + 1'b1;
      TX_SEND: if (!bus.tx_busy) begin
        tx_send_n = 1'b1;
        state_n   = TX_ACK;
        tmo_n     = '0;
      end
      TX_ACK: if (bus.tx_busy) state_n = TX_DONE;
      else if (tmo == TO_W'(TIMEOUT_CYC - 1)) begin
        state_n = IDLE;
        err_n   = sat_inc(err_n);
      end else tmo_n = tmo + 1'b1;
      TX_DONE: state_n = bus.tx_busy ? TX_DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
